serial_sub: RTL

- Bit-serial multi-bit subtractor. Computes a − b one bit per clock, LSB first.
- Per-bit core is the half-subtract equation extended with a registered borrow.
- Consumes the same a/b operands as the combinational half-subtractor stage. Produces a WIDTH-bit difference plus final borrow for downstream compare/ALU logic.
- Start/done handshake; one operation in flight at a time.

---
 rtl/serial_sub.sv | 72 +++++++
 1 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Start/done handshake; diff/bout are registered and held until the next result or reset.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, diff_q, sa_d;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q, busy_q, done_q, bout_q, d, br_d;
  assign d    = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  // The minuend register doubles as the result register: bits vacated at the top collect d.
  assign sa_d = {d, sa_q[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          sa_q  <= sa_d;
          sb_q  <= sb_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= sa_d;
            bout_q  <= br_d;
          end
        end
        default: begin
          if (start) begin
            state_q <= SHIFT;
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule
